// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, default reset vector, NOP word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP          = 32'h0000_0000;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC select: JR > J/JAL > taken BEQ/BNE > PC+4; zero latency, no flow control.
module next_pc_logic
    import fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic        i_branch_eq,
    input  logic        i_branch_ne,
    input  logic        i_zero,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic [15:0] i_branch_imm,
    input  logic [25:0] i_jump_target,
    input  logic [31:0] i_rs_value,
    output logic [31:0] o_next_pc
);

    logic w_branch_taken;

    // With both branch flags set, only the BEQ condition is honoured.
    assign w_branch_taken = i_branch_eq ? i_zero : (i_branch_ne & ~i_zero);

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump_reg) begin
            o_next_pc = i_rs_value & 32'hFFFF_FFFC;
        end else if (i_jump) begin
            o_next_pc = {i_pc_plus4[31:28], i_jump_target, 2'b00};
        end else if (w_branch_taken) begin
            o_next_pc = i_pc_plus4 + branch_offset(i_branch_imm);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/next-PC stage: PC register, BOOT/RUN/WAIT/ERROR FSM, imem timeout; one instr/cycle when imem ready.
// Stall holds PC, state and timeout counter. Optional retired/taken counters under FETCH_PERF_COUNTERS_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = FETCH_RESET_VECTOR,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_target,
    input  logic [31:0] rs_value,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_error
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] taken_count
`endif
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [7:0]   r_wait_cnt;
    logic         r_fetch_error;
    logic         r_imem_req;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_retire;
    logic [7:0]   w_wait_nxt;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_retire   = r_imem_req & imem_ready & ~stall;
    assign w_wait_nxt = r_wait_cnt + 8'd1;

    next_pc_logic u_next_pc (
        .i_pc_plus4    (w_pc_plus4),
        .i_branch_eq   (branch_eq),
        .i_branch_ne   (branch_ne),
        .i_zero        (zero),
        .i_jump        (jump),
        .i_jump_reg    (jump_reg),
        .i_branch_imm  (branch_imm),
        .i_jump_target (jump_target),
        .i_rs_value    (rs_value),
        .o_next_pc     (w_next_pc)
    );

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign imem_req    = r_imem_req;
    assign instr_valid = r_imem_req & imem_ready;
    assign instr       = (r_imem_req & imem_ready) ? imem_rdata : FETCH_NOP;
    assign fetch_error = r_fetch_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH_BOOT;
            r_pc          <= RESET_VECTOR;
            r_wait_cnt    <= 8'd0;
            r_fetch_error <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                FETCH_BOOT: begin
                    r_state    <= FETCH_RUN;
                    r_imem_req <= 1'b1;
                end
                FETCH_RUN, FETCH_WAIT: begin
                    if (w_retire) begin
                        r_pc       <= w_next_pc;
                        r_wait_cnt <= 8'd0;
                        r_state    <= FETCH_RUN;
                    end else if (!imem_ready && !stall) begin
                        // A stalled cycle freezes the timeout as well as the PC.
                        r_wait_cnt <= w_wait_nxt;
                        if (w_wait_nxt == TIMEOUT_LIMIT) begin
                            r_state       <= FETCH_ERROR;
                            r_fetch_error <= 1'b1;
                            r_imem_req    <= 1'b0;
                        end else begin
                            r_state <= FETCH_WAIT;
                        end
                    end
                end
                FETCH_ERROR: begin
                    r_imem_req <= 1'b0;
                end
                default: begin
                    r_state <= FETCH_ERROR;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_retired_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired_count <= 32'd0;
            r_taken_count   <= 32'd0;
        end else if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
            if (w_next_pc != w_pc_plus4) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign retired_count = r_retired_count;
    assign taken_count   = r_taken_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed PC-flow cases then randomized traffic against a behavioural model.
module tb_fetch_unit;

    localparam int          TMO = 4;
    localparam logic [31:0] RV  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;
    logic        jump;
    logic        jump_reg;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;
    logic [31:0] rs_value;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_error;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] retired_count;
    logic [31:0] taken_count;
`endif

    fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .zero        (zero),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch_imm  (branch_imm),
        .jump_target (jump_target),
        .rs_value    (rs_value),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_error (fetch_error)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .retired_count (retired_count),
        .taken_count   (taken_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_boot, m_active, m_err;
    int          m_waits;
    logic [31:0] m_ret, m_taken;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail_evt(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [31:0] model_next(logic [31:0] cur, bit beq, bit bne, bit z, bit j, bit jr,
                                               logic [15:0] imm, logic [25:0] tgt, logic [31:0] rs);
        logic [31:0] pc4;
        int          off;
        pc4 = cur + 32'd4;
        off = int'($signed(imm)) * 4;
        if (jr) return rs & 32'hFFFF_FFFC;
        if (j)  return (pc4 & 32'hF000_0000) | ({6'b0, tgt} << 2);
        if ((beq && z) || (!beq && bne && !z)) return pc4 + 32'(off);
        return pc4;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an instruction.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_valid) begin
                if (q.size() == 0) begin
                    fail_evt("unexpected_valid", pc, 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("out_pc", pc, e.pc);
                    chk("out_instr", instr, e.instr);
                    chk("out_pc_plus4", pc_plus4, e.pc4);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                fail_evt("missing_valid", 32'h0, q[0].pc);
                void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cyc_drive(input bit rdy, input bit stl, input bit beq, input bit bne, input bit z,
                             input bit j, input bit jr, input logic [15:0] imm, input logic [25:0] tgt,
                             input logic [31:0] rs);
        logic [31:0] nxt, word;
        word        = $urandom;
        imem_ready  = rdy;
        stall       = stl;
        branch_eq   = beq;
        branch_ne   = bne;
        zero        = z;
        jump        = j;
        jump_reg    = jr;
        branch_imm  = imm;
        jump_target = tgt;
        rs_value    = rs;
        imem_rdata  = word;
        nxt = model_next(m_pc, beq, bne, z, j, jr, imm, tgt, rs);
        if (m_active && rdy) q.push_back('{cyc, m_pc, word, m_pc + 32'd4});
        @(negedge clk);
        chk("imem_req", imem_req, m_active);
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_error", fetch_error, m_err);
        if (!(m_active && rdy)) chk("instr_idle", instr, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("retired_count", retired_count, m_ret);
        chk("taken_count", taken_count, m_taken);
`endif
        if (m_boot) begin
            m_boot   = 0;
            m_active = 1;
        end else if (m_active) begin
            if (rdy && !stl) begin
                m_ret++;
                if (nxt != m_pc + 32'd4) m_taken++;
                m_pc    = nxt;
                m_waits = 0;
            end else if (!rdy) begin
                m_waits++;
                if (m_waits == TMO) begin
                    m_active = 0;
                    m_err    = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input bit rdy);
        cyc_drive(rdy, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    endtask

    // Asynchronous reset raised mid-cycle; outputs must respond before any clock edge.
    task automatic do_reset();
        #2;
        reset      = 1'b1;
        imem_ready = 1'b1;
        stall      = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_pc_plus4", pc_plus4, RV + 32'd4);
        chk("rst_fetch_error", fetch_error, 32'h0);
        chk("rst_imem_req", imem_req, 32'h0);
        chk("rst_instr_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_pc     = RV;
        m_boot   = 1;
        m_active = 0;
        m_err    = 0;
        m_waits  = 0;
        m_ret    = 0;
        m_taken  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ready = 0; stall = 0; imem_rdata = 0;
        branch_eq = 0; branch_ne = 0; zero = 0; jump = 0; jump_reg = 0;
        branch_imm = 0; jump_target = 0; rs_value = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Boot cycle then sequential fetch 0,4,8,C
        plain(1);
        repeat (3) plain(1);
        chk("seq_pc_c", pc, 32'h0000_000C);
        cyc_drive(1, 0, 0, 1, 0, 0, 0, 16'hFFFC, 26'h0, 32'h0);
        chk("bne_taken", pc, 32'h0000_0000);
        repeat (3) plain(1);
        cyc_drive(1, 0, 0, 1, 1, 0, 0, 16'hFFFC, 26'h0, 32'h0);
        chk("bne_not_taken", pc, 32'h0000_0010);

        // Priority: JR over J, then J alone, then BEQ over BNE
        cyc_drive(1, 0, 0, 0, 0, 1, 1, 16'h0, 26'h3FF_FFFF, 32'h0000_0040);
        chk("jr_over_j", pc, 32'h0000_0040);
        cyc_drive(1, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h1000_0003);
        chk("jr_mask", pc, 32'h1000_0000);
        cyc_drive(1, 0, 0, 0, 0, 1, 0, 16'h0, 26'h10, 32'h0);
        chk("jump", pc, 32'h1000_0040);
        cyc_drive(1, 0, 1, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0);
        chk("beq_bne_z1", pc, 32'h1000_0084);
        cyc_drive(1, 0, 1, 1, 0, 0, 0, 16'h0010, 26'h0, 32'h0);
        chk("beq_bne_z0", pc, 32'h1000_0088);

        // Stall with ready memory: PC and counters hold
        repeat (3) cyc_drive(1, 1, 0, 0, 0, 1, 0, 16'h0, 26'h55, 32'h0);
        chk("stall_hold", pc, 32'h1000_0088);
        plain(1);
        chk("stall_release", pc, 32'h1000_008C);

        // Wrap around 2^32 both ways
        cyc_drive(1, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFFC);
        chk("jr_top", pc, 32'hFFFF_FFFC);
        plain(1);
        chk("wrap_fwd", pc, 32'h0000_0000);
        cyc_drive(1, 0, 1, 0, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0);
        chk("wrap_back", pc, 32'hFFFF_FFFC);

        // Timeout to ERROR; later ready is ignored
        repeat (TMO - 1) plain(0);
        chk("pre_timeout_err", fetch_error, 32'h0);
        plain(0);
        chk("timeout_err", fetch_error, 32'h1);
        chk("timeout_req", imem_req, 32'h0);
        repeat (3) plain(1);
        chk("error_sticky", fetch_error, 32'h1);
        chk("error_pc_frozen", pc, 32'hFFFF_FFFC);
        do_reset();

        // Async reset in the middle of WAIT
        plain(1);
        repeat (2) plain(1);
        repeat (2) plain(0);
        chk("wait_pc", pc, 32'h0000_0008);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit rdy, stl;
            if (m_err || $urandom_range(0, 99) == 0) do_reset();
            rdy = ($urandom_range(0, 2) != 0);
            stl = rdy && ($urandom_range(0, 4) == 0);
            cyc_drive(rdy, stl, 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      16'($urandom), 26'($urandom), $urandom);
        end

        plain(1);
        plain(1);
        chk("queue_drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
